alu_exec: RTL and testbench

Execution-stage ALU for the RISC-V core: consumes the 4-bit ALU control code that the ALU control decoder produces, plus two operands, and returns a registered result with a zero flag. AND/OR/ADD/SUB complete in one cycle. MUL runs on an iterative shift-add multiplier over WIDTH cycles, and during that time the block raises stall_o so the hazard unit can freeze the pipeline. A valid/ready handshake sits on the input side and a one-cycle valid pulse on the output side.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_exec_mul_iter.sv | 50 +++++
 rtl/alu_exec.sv | 90 +++++++++
 tb/tb_alu_exec.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and execution-stage FSM state type.
// Used by both the ALU control decoder and the execution-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTRL_MUL = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, LSB first.
// done marks the edge that consumes the last bit; product is the acc value after that edge.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] step_sum;

  assign step_sum = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == CNT_W'(WIDTH - 1));
  assign product  = step_sum;

  always_ff @(posedge clk_i) begin
    if (clear) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
    end else if (busy) begin
      acc    <= step_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execution-stage ALU: single-cycle AND/OR/ADD/SUB, iterative MUL with pipeline stall.
// Results are registered and announced with a one-cycle valid_o pulse.
//
//   state | meaning
//   IDLE  | ready for a request; simple ops complete here in one cycle
//   MUL   | multiply in progress, requests refused, stall_o high
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             stall_o
);

  alu_state_t       state;
  logic             accept;
  logic             start_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] simple_result;

  assign ready_o   = (state == IDLE);
  assign stall_o   = ~ready_o;
  assign accept    = valid_i && ready_o;
  assign start_mul = accept && (ALUCtrl_i == ALU_CTRL_MUL);

  // Unknown codes deliberately yield zero so the pipeline still sees a result.
  always_comb begin
    simple_result = '0;
    unique case (ALUCtrl_i)
      ALU_CTRL_AND: simple_result = data1_i & data2_i;
      ALU_CTRL_OR:  simple_result = data1_i | data2_i;
      ALU_CTRL_ADD: simple_result = data1_i + data2_i;
      ALU_CTRL_SUB: simple_result = data1_i - data2_i;
      default:      simple_result = '0;
    endcase
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
    .clk_i   (clk_i),
    .clear   (rst_i),
    .start   (start_mul),
    .op_a    (data1_i),
    .op_b    (data2_i),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      data_o  <= '0;
      zero_o  <= 1'b1;
    end else begin
      valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_mul) begin
            state <= MUL;
          end else if (accept) begin
            data_o  <= simple_result;
            zero_o  <= (simple_result == '0);
            valid_o <= 1'b1;
          end
        end
        MUL: begin
          if (mul_done) begin
            data_o  <= mul_product;
            zero_o  <= (mul_product == '0);
            valid_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: a latency-level reference model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_alu_exec;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             valid_i = 1'b0;
  logic [3:0]       ALUCtrl_i = 4'b0000;
  logic [WIDTH-1:0] data1_i = '0;
  logic [WIDTH-1:0] data2_i = '0;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             stall_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  alu_exec #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .zero_o    (zero_o),
    .stall_o   (stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Reference model: a multiply is just "result appears WIDTH edges after accept".
  logic             m_busy = 1'b0;
  int               m_left = 0;
  logic [WIDTH-1:0] m_data = '0;
  logic [WIDTH-1:0] m_pending = '0;
  logic             m_valid = 1'b0;

  always @(posedge clk_i) begin
    m_valid = 1'b0;
    if (rst_i) begin
      m_busy = 1'b0;
      m_left = 0;
      m_data = '0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy  = 1'b0;
        m_data  = m_pending;
        m_valid = 1'b1;
      end
    end else if (valid_i) begin
      if (ALUCtrl_i == 4'b1000) begin
        m_busy    = 1'b1;
        m_left    = WIDTH;
        m_pending = data1_i * data2_i;
      end else begin
        m_data  = ref_op(ALUCtrl_i, data1_i, data2_i);
        m_valid = 1'b1;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("model valid_o", WIDTH'(valid_o), WIDTH'(m_valid));
      check("model data_o",  data_o, m_data);
      check("model zero_o",  WIDTH'(zero_o), WIDTH'(m_data == '0));
      check("model ready_o", WIDTH'(ready_o), WIDTH'(!m_busy));
      check("model stall_o", WIDTH'(stall_o), WIDTH'(m_busy));
    end
  end

  task automatic drive(input logic [3:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    valid_i   = 1'b1;
    ALUCtrl_i = c;
    data1_i   = a;
    data2_i   = b;
  endtask

  task automatic op_chk(input string name, input logic [3:0] c, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    @(negedge clk_i);
    drive(c, a, b);
    @(negedge clk_i);
    valid_i = 1'b0;
    check({name, " valid"}, WIDTH'(valid_o), 1);
    check({name, " data"},  data_o, exp);
    check({name, " zero"},  WIDTH'(zero_o), WIDTH'(exp == '0));
  endtask

  task automatic mul_chk(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp, input bit hold_add);
    int stalls;
    bit got;
    stalls = 0;
    got    = 1'b0;
    @(negedge clk_i);
    drive(4'b1000, a, b);
    @(negedge clk_i);
    if (hold_add) drive(4'b0010, 1, 1);
    else valid_i = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (valid_o) got = 1'b1;
      else begin
        if (stall_o) stalls++;
        @(negedge clk_i);
      end
    end
    check({name, " result seen"}, WIDTH'(got), 1);
    check({name, " stall cycles"}, WIDTH'(stalls), WIDTH);
    check({name, " data"}, data_o, exp);
    check({name, " zero"}, WIDTH'(zero_o), WIDTH'(exp == '0));
    check({name, " ready"}, WIDTH'(ready_o), 1);
    if (hold_add) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      check({name, " held add valid"}, WIDTH'(valid_o), 1);
      check({name, " held add data"}, data_o, 2);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    chk_en = 1'b1;
    check("reset ready_o", WIDTH'(ready_o), 1);
    check("reset stall_o", WIDTH'(stall_o), 0);
    check("reset valid_o", WIDTH'(valid_o), 0);
    check("reset data_o",  data_o, 0);
    check("reset zero_o",  WIDTH'(zero_o), 1);
    rst_i = 1'b0;

    op_chk("add 5+7", 4'b0010, 5, 7, 12);
    op_chk("sub 7-7", 4'b0110, 7, 7, 0);
    op_chk("sub 0-1", 4'b0110, 0, 1, 32'hFFFF_FFFF);

    @(negedge clk_i);
    drive(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
    @(negedge clk_i);
    drive(4'b0001, 32'h0000_F0F0, 32'h0000_0FF0);
    check("b2b and valid", WIDTH'(valid_o), 1);
    check("b2b and data", data_o, 32'h0000_00F0);
    check("b2b ready", WIDTH'(ready_o), 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    check("b2b or valid", WIDTH'(valid_o), 1);
    check("b2b or data", data_o, 32'h0000_FFF0);

    mul_chk("mul 6*7", 6, 7, 42, 1'b0);
    mul_chk("mul ffffffff*2", 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 1'b0);
    mul_chk("mul 2^16*2^16", 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
    mul_chk("mul 3*5 with held add", 3, 5, 15, 1'b1);

    @(negedge clk_i);
    drive(4'b1000, 32'h0000_1234, 32'h0000_5678);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    drive(4'b0010, 9, 9);
    @(negedge clk_i);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    check("abort valid_o", WIDTH'(valid_o), 0);
    check("abort data_o", data_o, 0);
    check("abort zero_o", WIDTH'(zero_o), 1);
    check("abort ready_o", WIDTH'(ready_o), 1);
    op_chk("add 3+4 after abort", 4'b0010, 3, 4, 7);

    op_chk("unknown code", 4'b1111, 32'h1234_5678, 1, 0);

    repeat (WIDTH + 4) @(negedge clk_i);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
